alu_op_sequencer: RTL and testbench

- Registered issue/capture stage around the combinational 4-bit function units of the 16-function ALU.
- Accepts an operation (A, B, 4-bit select) over a valid/ready handshake and drives the operands plus a one-hot enable to the units.
- Holds the enable for a programmable settle time, then captures the selected unit's result and flags into an output register.
- Presents the result over a second valid/ready handshake.
- Upstream of the units as operand/enable source; downstream of them as result consumer.

---
 rtl/alu_op_sequencer.sv | 150 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Registered issue/capture stage wrapped around the combinational 4-bit
//   function units of the 16-function ALU. An operation (A, B, select) is
//   accepted over a valid/ready handshake. The operands and a one-hot unit
//   enable are then driven for SETTLE cycles. On the last of those cycles the
//   enabled unit's result and carry are captured, and the result is offered
//   over a second valid/ready handshake.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       request handshake
//   in_a, in_b, in_sel      operands and function select (0..15)
//   opa, opb, en            operands and one-hot enable to the units
//   fu_y, fu_co             result and carry returned by the enabled unit
//   out_valid/out_ready     result handshake
//   out_y, out_z, out_c     captured result, zero flag, carry
//   busy                    high whenever an op is in flight or unretired
module alu_op_sequencer #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_a,
    input  logic [3:0]  in_b,
    input  logic [3:0]  in_sel,
    output logic [3:0]  opa,
    output logic [3:0]  opb,
    output logic [15:0] en,
    input  logic [3:0]  fu_y,
    input  logic        fu_co,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_y,
    output logic        out_z,
    output logic        out_c,
    output logic        busy
);

    // A SETTLE of 0 is treated as 1. Values above 15 do not fit the counter
    // and are clamped.
    localparam logic [3:0] SETTLE_EFF = (SETTLE < 1)  ? 4'd1  :
                                        (SETTLE > 15) ? 4'd15 : 4'(SETTLE);

    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  opa_q, opa_d;
    logic [3:0]  opb_q, opb_d;
    logic [15:0] en_q, en_d;
    logic [3:0]  out_y_q, out_y_d;
    logic        out_z_q, out_z_d;
    logic        out_c_q, out_c_d;
    logic        out_valid_q, out_valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            en_q        <= '0;
            out_y_q     <= '0;
            out_z_q     <= 1'b0;
            out_c_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            en_q        <= en_d;
            out_y_q     <= out_y_d;
            out_z_q     <= out_z_d;
            out_c_q     <= out_c_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        en_d        = en_q;
        out_y_d     = out_y_q;
        out_z_d     = out_z_q;
        out_c_d     = out_c_q;
        out_valid_d = out_valid_q;
        in_ready    = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    opa_d   = in_a;
                    opb_d   = in_b;
                    en_d    = 16'd1 << in_sel;
                    cnt_d   = SETTLE_EFF;
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_q - 4'd1;
                // Capture on the last settle cycle. The <= guard keeps a
                // corrupted zero count from wrapping into a 16-cycle stall.
                if (cnt_q <= 4'd1) begin
                    out_y_d     = fu_y;
                    out_z_d     = (fu_y == 4'd0);
                    out_c_d     = fu_co;
                    out_valid_d = 1'b1;
                    en_d        = '0;
                    cnt_d       = '0;
                    state_d     = RESP;
                end
            end
            RESP: begin
                // A new op may be accepted only on the edge that retires the
                // current result. Otherwise the result registers would be
                // overwritten before they are consumed.
                in_ready = out_ready;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (in_valid) begin
                        opa_d   = in_a;
                        opb_d   = in_b;
                        en_d    = 16'd1 << in_sel;
                        cnt_d   = SETTLE_EFF;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign opa       = opa_q;
    assign opb       = opb_q;
    assign en        = en_q;
    assign out_y     = out_y_q;
    assign out_z     = out_z_q;
    assign out_c     = out_c_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Three sequencers are instantiated, with SETTLE = 1, 3 and 4. Each one is
// driven by a behavioural model of the function units. Expected results come
// from the requested operation (select, A, B) and the settle length, never
// from DUT state.
module tb_alu_op_sequencer;

  logic        clk;
  logic        rst_n     [3];
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [3:0]  in_a      [3];
  logic [3:0]  in_b      [3];
  logic [3:0]  in_sel    [3];
  logic [3:0]  opa       [3];
  logic [3:0]  opb       [3];
  logic [15:0] en        [3];
  logic [3:0]  fu_y      [3];
  logic        fu_co     [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [3:0]  out_y     [3];
  logic        out_z     [3];
  logic        out_c     [3];
  logic        busy      [3];
  logic        noise_on  [3];
  logic [4:0]  noise_val [3];

  int n_chk  = 0;
  int n_pass = 0;

  function automatic int settle_of(int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
  endfunction

  // Function-unit behaviour: {carry, y}. Select 3 is a decrement (borrow out
  // when A is 0). Every other select is A + B + sel with carry out.
  function automatic logic [4:0] ref_fu(int sel, logic [3:0] a, logic [3:0] b);
    logic [4:0] r;
    if (sel == 3) r = {(a == 4'd0), 4'(a - 4'd1)};
    else          r = {1'b0, a} + {1'b0, b} + 5'(sel);
    return r;
  endfunction

  function automatic logic [4:0] fu_model(logic [15:0] e, logic [3:0] a, logic [3:0] b);
    int s = -1;
    for (int k = 0; k < 16; k++) if (e[k]) s = k;
    if (s < 0) return 5'd0;
    return ref_fu(s, a, b);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    alu_op_sequencer #(.SETTLE(g == 0 ? 1 : (g == 1 ? 3 : 4))) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_a      (in_a[g]),
      .in_b      (in_b[g]),
      .in_sel    (in_sel[g]),
      .opa       (opa[g]),
      .opb       (opb[g]),
      .en        (en[g]),
      .fu_y      (fu_y[g]),
      .fu_co     (fu_co[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_y     (out_y[g]),
      .out_z     (out_z[g]),
      .out_c     (out_c[g]),
      .busy      (busy[g])
    );
    assign {fu_co[g], fu_y[g]} = noise_on[g] ? noise_val[g] : fu_model(en[g], opa[g], opb[g]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Drives the request at the negedge and checks the accept edge.
  task automatic accept_op(int i, logic [3:0] a, logic [3:0] b, logic [3:0] sel);
    @(negedge clk);
    in_a[i] = a; in_b[i] = b; in_sel[i] = sel;
    in_valid[i] = 1'b1; out_ready[i] = 1'b1;
    #1 chk("in_ready_pre", in_ready[i], 1);
    @(posedge clk); #1;
    in_valid[i] = 1'b0;
    chk("en_accept", en[i], 32'(16'd1 << sel));
    chk("opa", opa[i], a);
    chk("opb", opb[i], b);
    chk("busy", busy[i], 1);
    chk("ov_low", out_valid[i], 0);
  endtask

  // Runs the settle cycles. When noise is set, fu_y carries garbage on every
  // cycle except the capture cycle.
  task automatic finish_op(int i, logic [3:0] a, logic [3:0] b, logic [3:0] sel, bit noise);
    int s = settle_of(i);
    logic [4:0] r = ref_fu(int'(sel), a, b);
    for (int c = 1; c <= s; c++) begin
      @(negedge clk);
      noise_on[i]  = noise && (c < s);
      noise_val[i] = 5'($urandom);
      chk("en_hold", en[i], 32'(16'd1 << sel));
      chk("in_ready_run", in_ready[i], 0);
      chk("ov_run", out_valid[i], 0);
      @(posedge clk); #1;
    end
    noise_on[i] = 1'b0;
    chk("ov_rise", out_valid[i], 1);
    chk("en_off", en[i], 0);
    chk("out_y", out_y[i], r[3:0]);
    chk("out_z", out_z[i], (r[3:0] == 4'd0));
    chk("out_c", out_c[i], r[4]);
  endtask

  task automatic run_op(int i, logic [3:0] a, logic [3:0] b, logic [3:0] sel, bit noise);
    accept_op(i, a, b, sel);
    finish_op(i, a, b, sel, noise);
  endtask

  initial begin
    logic [3:0] a, b, sel, a2, b2, sel2, held_y;
    logic [4:0] r;
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; in_valid[i] = 1'b0; in_a[i] = '0; in_b[i] = '0;
      in_sel[i] = '0; out_ready[i] = 1'b0; noise_on[i] = 1'b0; noise_val[i] = '0;
    end
    #12;
    for (int i = 0; i < 3; i++) begin
      chk("rst_en", en[i], 0);
      chk("rst_ov", out_valid[i], 0);
      chk("rst_y", out_y[i], 0);
      chk("rst_busy", busy[i], 0);
      chk("rst_in_ready", in_ready[i], 1);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

    // Decrement wrap on the SETTLE=1 instance: 0 - 1 -> F with borrow.
    run_op(0, 4'h0, 4'h5, 4'd3, 1'b0);
    // Zero flag on the SETTLE=4 instance: 1 - 1 -> 0.
    run_op(2, 4'h1, 4'h9, 4'd3, 1'b0);

    // Sample isolation on the SETTLE=3 instance.
    for (int n = 0; n < 4; n++) run_op(1, 4'($urandom), 4'($urandom), 4'($urandom), 1'b1);

    // Backpressure on each instance: the pending op waits behind the result.
    for (int i = 0; i < 3; i++) begin
      a = 4'($urandom); b = 4'($urandom); sel = 4'($urandom);
      run_op(i, a, b, sel, 1'b0);
      r = ref_fu(int'(sel), a, b);
      held_y = r[3:0];
      a2 = 4'($urandom); b2 = 4'($urandom); sel2 = 4'($urandom);
      @(negedge clk);
      out_ready[i] = 1'b0; in_valid[i] = 1'b1;
      in_a[i] = a2; in_b[i] = b2; in_sel[i] = sel2;
      for (int c = 0; c < 6; c++) begin
        #1;
        chk("bp_in_ready", in_ready[i], 0);
        chk("bp_en", en[i], 0);
        chk("bp_ov", out_valid[i], 1);
        chk("bp_y", out_y[i], held_y);
        @(negedge clk);
      end
      out_ready[i] = 1'b1;
      #1 chk("bp_release_ready", in_ready[i], 1);
      @(posedge clk); #1;
      in_valid[i] = 1'b0;
      chk("bp_en_new", en[i], 32'(16'd1 << sel2));
      chk("bp_ov_retired", out_valid[i], 0);
      chk("bp_opa", opa[i], a2);
      finish_op(i, a2, b2, sel2, 1'b0);
    end

    // Back-to-back stream on SETTLE=1: one result every two cycles.
    begin
      int got = 0;
      @(negedge clk);
      out_ready[0] = 1'b1;
      for (int s = 0; s < 16; s++) begin
        a = 4'($urandom); b = 4'($urandom);
        in_a[0] = a; in_b[0] = b; in_sel[0] = 4'(s); in_valid[0] = 1'b1;
        #1 chk("b2b_ready", in_ready[0], 1);
        @(posedge clk); #1;
        chk("b2b_en", en[0], 32'(16'd1 << s));
        @(negedge clk);
        chk("b2b_ov_low", out_valid[0], 0);
        @(posedge clk); #1;
        r = ref_fu(s, a, b);
        if (out_valid[0] === 1'b1) got++;
        chk("b2b_y", out_y[0], r[3:0]);
        @(negedge clk);
      end
      in_valid[0] = 1'b0;
      chk("b2b_count", got, 16);
    end

    // Asynchronous reset in the middle of RUN (SETTLE=3, en=0x0008).
    accept_op(1, 4'h7, 4'h2, 4'd3);
    @(negedge clk);
    #2 rst_n[1] = 1'b0;
    #1;
    chk("arst_en", en[1], 0);
    chk("arst_opa", opa[1], 0);
    chk("arst_opb", opb[1], 0);
    chk("arst_busy", busy[1], 0);
    chk("arst_ov", out_valid[1], 0);
    chk("arst_y", {out_z[1], out_c[1], out_y[1]}, 0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    #1;
    chk("arst_rel_ready", in_ready[1], 1);
    chk("arst_rel_ov", out_valid[1], 0);
    repeat (4) @(posedge clk);
    #1 chk("arst_no_result", out_valid[1], 0);

    // Randomized mix with random consumer stalls.
    for (int n = 0; n < 30; n++) begin
      int i = $urandom_range(0, 2);
      run_op(i, 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        out_ready[i] = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        #1 chk("rnd_stall_ov", out_valid[i], 1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
